test_result_monitor: RTL
========================

Name: test_result_monitor

Overview:
- Synthesizable completion monitor for riscv-tests ISA runs. Sits directly downstream of the core.
- Snoops the core's PC and gp (x3) value, and the data-memory write port for tohost stores.
- Produces a sticky pass/fail/timeout verdict, the failing test number and a cycle count.
- Replaces per-test bench PC polling. Benches and the FPGA top read its outputs.

Parameters:
- END_PC, 32'h0000_0044, PC of the test's terminal loop; reaching it ends the run.
- TOHOST_ADDR, 32'h0000_1000, word address of tohost for store snooping.
- TIMEOUT, 5000, cycles in RUN before the run is declared timed out (must be ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse: begin a run (accepted in IDLE only).
- clear  in  1  synchronous return to IDLE from any state. Clears all outputs.
- pc_valid  in  1  pc/gp are valid this cycle (instruction retiring).
- pc  in  32  retiring PC.
- gp  in  32  current x3 value.
- st_en  in  1  data-memory store strobe.
- st_addr  in  32  store address.
- st_data  in  32  store data.
- busy  out  1  state == RUN.
- done  out  1  verdict latched (PASS/FAIL/TIMEOUT).
- passed  out  1  verdict PASS.
- failed  out  1  verdict FAIL.
- timeout  out  1  verdict TIMEOUT.
- fail_test_num  out  31  failing test number (valid when failed).
- cycle_count  out  32  cycles spent in RUN, saturating at 32'hFFFF_FFFF.

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0.
- States are IDLE, RUN, PASS, FAIL, TIMEOUT. All outputs are registered.
- Event evaluation happens in RUN only. Outputs change the cycle after the triggering edge.

- IDLE:
  - start=1 → RUN. cycle_count←0.
  - Snoop inputs are ignored.
- RUN: each cycle, cycle_count increments (saturating). Event priority: tohost > end-PC > timeout.
  - tohost event: st_en && st_addr==TOHOST_ADDR && st_data[0]==1.
    - st_data==1 → PASS.
    - Otherwise → FAIL, fail_test_num←st_data[31:1].
    - A store with st_data[0]==0 is ignored.
  - end-PC event: pc_valid && pc==END_PC.
    - gp==1 → PASS.
    - Otherwise → FAIL, fail_test_num←gp[31:1].
    - If gp==0, fail_test_num=0 and FAIL is still reported.
  - timeout: the cycle_count value being replaced equals TIMEOUT-1, and no other event occurs → TIMEOUT. A pass/fail event in that same cycle wins.
  - start in RUN is ignored.
- PASS/FAIL/TIMEOUT are sticky.
  - Snoop inputs, start and further stores are ignored.
  - cycle_count freezes at its final value.
  - fail_test_num is held; it is 0 in PASS and TIMEOUT.
- Output encodings:
  - done = passed|failed|timeout. At most one verdict bit is 1.
  - busy=1 only in RUN.
- clear=1: → IDLE next edge, all outputs 0. clear has priority over start and over all RUN events.
- Reset mid-run: verdict and counter are lost immediately (async). The monitor is in IDLE when rst releases.
- Width rules:
  - All comparisons are full 32-bit equality.
  - fail_test_num is an unsigned 31-bit field.
  - cycle_count saturates; it never wraps.

Test Plan:
- Pass by PC: start; after 10 cycles drive pc_valid=1, pc=32'h44, gp=1 → next cycle passed=1, done=1, busy=0, cycle_count=11, fail_test_num=0. Holds after pc changes.
- Fail by PC: start; pc=32'h44, gp=32'h0000_0007 → failed=1, fail_test_num=3. A later gp=1 at 32'h44 does not change the verdict.
- tohost priority: in one RUN cycle, st_en=1, st_addr=32'h1000, st_data=32'h0000_000B, plus pc=32'h44, gp=1 → failed=1, fail_test_num=5. Also: st_data=32'h2 → ignored, still busy.
- Timeout: TIMEOUT=20, start, no events → timeout=1 after 20 RUN cycles, cycle_count=20. Repeat with an end-PC pass on the 20th cycle → passed=1, timeout=0.
- Reset/clear: assert rst=0 mid-RUN asynchronously → all outputs 0 before the next edge, IDLE after release, start required to resume. After PASS, clear=1 together with start=1 → IDLE, outputs 0, start ignored.
- Idle snooping: without start, drive pc=32'h44, gp=1 and a tohost store → outputs stay 0, cycle_count=0.

Source files
------------

// File: rtl/test_result_monitor.sv
// Completion monitor for riscv-tests runs: watches tohost stores and the
// terminal-loop PC, latches a sticky verdict, failing test number and cycles.
//
// Ports:
//   clk, rst          clock (rising edge), async active-low reset
//   start, clear      begin a run (IDLE only) / sync return to IDLE
//   pc_valid, pc, gp  retiring PC and x3 snoop
//   st_en, st_addr,   data-memory store snoop
//   st_data
//   busy, done        in RUN / verdict latched
//   passed, failed,   one-hot verdict bits
//   timeout
//   fail_test_num     failing test number (31 bits)
//   cycle_count       saturating RUN cycle count
module test_result_monitor #(
  parameter logic [31:0] END_PC      = 32'h0000_0044,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
  parameter int unsigned TIMEOUT     = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clear,
  input  logic        pc_valid,
  input  logic [31:0] pc,
  input  logic [31:0] gp,
  input  logic        st_en,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        busy,
  output logic        done,
  output logic        passed,
  output logic        failed,
  output logic        timeout,
  output logic [30:0] fail_test_num,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TMO
  } state_e;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [30:0] ftn_q, ftn_d;

  logic tohost_ev;
  logic endpc_ev;

  assign tohost_ev = st_en && (st_addr == TOHOST_ADDR)
                     && st_data[0];
  assign endpc_ev  = pc_valid && (pc == END_PC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ftn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ftn_q   <= ftn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ftn_d   = ftn_q;
    if (clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ftn_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_RUN;
            cnt_d   = '0;
            ftn_d   = '0;
          end
        end
        S_RUN: begin
          if (cnt_q != 32'hFFFF_FFFF) begin
            cnt_d = cnt_q + 32'd1;
          end
          if (tohost_ev) begin
            if (st_data == 32'd1) begin
              state_d = S_PASS;
            end else begin
              state_d = S_FAIL;
              ftn_d   = st_data[31:1];
            end
          end else if (endpc_ev) begin
            if (gp == 32'd1) begin
              state_d = S_PASS;
            end else begin
              state_d = S_FAIL;
              ftn_d   = gp[31:1];
            end
          end else if (cnt_q == TO_LAST) begin
            // count being replaced is TIMEOUT-1, so
            // the frozen value reads back as TIMEOUT
            state_d = S_TMO;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    busy          = (state_q == S_RUN);
    passed        = (state_q == S_PASS);
    failed        = (state_q == S_FAIL);
    timeout       = (state_q == S_TMO);
    done          = passed | failed | timeout;
    fail_test_num = ftn_q;
    cycle_count   = cnt_q;
  end

endmodule
